// File: rtl/mem_level.sv
// MEM pipeline stage: byte-addressable data memory with word/half/byte access,
// WB-to-store-data forwarding, and the MEM/WB pipeline register.
module mem_level #(
  parameter int DM_WORDS    = 4096,
  parameter int DM_AW       = 12,
  parameter int WIDTH_INSTR = 6,
  parameter int WIDTH_T     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   clr,
  input  logic [WIDTH_INSTR-1:0] instr_MEM,
  input  logic [31:0]            PC_MEM,
  input  logic [31:0]            aluOut_MEM,
  input  logic [31:0]            memWriteData_MEM,
  input  logic [4:0]             addrRt_MEM,
  input  logic [4:0]             regWriteAddr_MEM,
  input  logic [31:0]            regWriteData_MEM,
  input  logic [WIDTH_T-1:0]     Tnew_MEM,
  input  logic [4:0]             regaddr_WB,
  input  logic [31:0]            regdata_WB,
  output logic [31:0]            regWriteData,
  output logic                   addrErr,
  output logic [WIDTH_INSTR-1:0] instr_WB,
  output logic [31:0]            PC_WB,
  output logic [4:0]             regWriteAddr_WB,
  output logic [31:0]            regWriteData_WB,
  output logic [WIDTH_T-1:0]     Tnew_WB
);

  // Decoded instruction ids for the memory operations; every other id is a non-memory op.
  localparam logic [WIDTH_INSTR-1:0] I_LW  = WIDTH_INSTR'(1);
  localparam logic [WIDTH_INSTR-1:0] I_LH  = WIDTH_INSTR'(2);
  localparam logic [WIDTH_INSTR-1:0] I_LHU = WIDTH_INSTR'(3);
  localparam logic [WIDTH_INSTR-1:0] I_LB  = WIDTH_INSTR'(4);
  localparam logic [WIDTH_INSTR-1:0] I_LBU = WIDTH_INSTR'(5);
  localparam logic [WIDTH_INSTR-1:0] I_SW  = WIDTH_INSTR'(6);
  localparam logic [WIDTH_INSTR-1:0] I_SH  = WIDTH_INSTR'(7);
  localparam logic [WIDTH_INSTR-1:0] I_SB  = WIDTH_INSTR'(8);

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] hs;
    logic signed [31:0] s;
    hs = signed'(h);
    s  = hs;
    return sgn ? s : {16'h0000, h};
  endfunction

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  bs;
    logic signed [31:0] s;
    bs = signed'(b);
    s  = bs;
    return sgn ? s : {24'h000000, b};
  endfunction

  logic [31:0]      mem [DM_WORDS];
  logic [DM_AW-1:0] idx;
  logic [1:0]       off;
  logic             in_range;
  logic             is_load, is_store, word_op, half_op, misaligned;
  logic [3:0]       be;
  logic [31:0]      wdata, wbytes;
  logic [31:0]      rword, load_data;
  logic [15:0]      rhalf;
  logic [7:0]       rbyte;
  logic [WIDTH_T-1:0] tnew;

  assign idx      = aluOut_MEM[DM_AW+1:2];
  assign off      = aluOut_MEM[1:0];
  assign in_range = (aluOut_MEM[31:DM_AW+2] == '0);

  // A store whose rt is being written back this cycle takes the WB value.
  assign wdata = (regaddr_WB == addrRt_MEM && regaddr_WB != 5'd0) ? regdata_WB : memWriteData_MEM;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    word_op  = 1'b0;
    half_op  = 1'b0;
    be       = 4'b0000;
    wbytes   = wdata;
    case (instr_MEM)
      I_LW:        begin is_load = 1'b1; word_op = 1'b1; end
      I_LH, I_LHU: begin is_load = 1'b1; half_op = 1'b1; end
      I_LB, I_LBU: is_load = 1'b1;
      I_SW:        begin is_store = 1'b1; word_op = 1'b1; be = 4'b1111; end
      I_SH: begin
        is_store = 1'b1;
        half_op  = 1'b1;
        be       = 4'b0011 << off;
        wbytes   = {2{wdata[15:0]}};
      end
      I_SB: begin
        is_store = 1'b1;
        be       = 4'b0001 << off;
        wbytes   = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign misaligned = (word_op && off != 2'b00) || (half_op && off[0]);
  assign addrErr    = (is_load || is_store) && (misaligned || !in_range);

  assign rword = mem[idx];
  assign rhalf = off[1] ? rword[31:16] : rword[15:0];
  assign rbyte = rword[8*off +: 8];

  always_comb begin
    load_data = 32'h0;
    case (instr_MEM)
      I_LW:    load_data = rword;
      I_LH:    load_data = ext16(rhalf, 1'b1);
      I_LHU:   load_data = ext16(rhalf, 1'b0);
      I_LB:    load_data = ext8(rbyte, 1'b1);
      I_LBU:   load_data = ext8(rbyte, 1'b0);
      default: load_data = 32'h0;
    endcase
  end

  assign regWriteData = is_load ? (addrErr ? 32'h0 : load_data) : regWriteData_MEM;
  assign tnew         = (Tnew_MEM != '0) ? Tnew_MEM - WIDTH_T'(1) : '0;

  // Store commit: clr only bubbles MEM/WB, so it does not block the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= 32'h0;
    end else if (is_store && !addrErr && !stall) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[idx][8*k +: 8] <= wbytes[8*k +: 8];
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      instr_WB        <= '0;
      PC_WB           <= 32'h0;
      regWriteAddr_WB <= 5'd0;
      regWriteData_WB <= 32'h0;
      Tnew_WB         <= '0;
    end else if (!stall) begin
      instr_WB        <= instr_MEM;
      PC_WB           <= PC_MEM;
      regWriteAddr_WB <= regWriteAddr_MEM;
      regWriteData_WB <= regWriteData;
      Tnew_WB         <= tnew;
    end
  end

endmodule

// File: tb/tb_mem_level.sv
// Bench for mem_level: byte-addressed reference model checked every cycle,
// directed literal checks from the test plan, then a randomized run.
module tb_mem_level;

  localparam logic [5:0] INOP = 6'd0, ILW = 6'd1, ILH = 6'd2, ILHU = 6'd3, ILB = 6'd4,
                         ILBU = 6'd5, ISW = 6'd6, ISH = 6'd7, ISB = 6'd8, IALU = 6'd9;

  logic        clk = 1'b0;
  logic        reset, stall, clr;
  logic [5:0]  instr_MEM;
  logic [31:0] PC_MEM, aluOut_MEM, memWriteData_MEM, regWriteData_MEM, regdata_WB;
  logic [4:0]  addrRt_MEM, regWriteAddr_MEM, regaddr_WB;
  logic [1:0]  Tnew_MEM;
  logic [31:0] regWriteData, PC_WB, regWriteData_WB;
  logic        addrErr;
  logic [5:0]  instr_WB;
  logic [4:0]  regWriteAddr_WB;
  logic [1:0]  Tnew_WB;

  mem_level dut (
    .clk(clk), .reset(reset), .stall(stall), .clr(clr),
    .instr_MEM(instr_MEM), .PC_MEM(PC_MEM), .aluOut_MEM(aluOut_MEM),
    .memWriteData_MEM(memWriteData_MEM), .addrRt_MEM(addrRt_MEM),
    .regWriteAddr_MEM(regWriteAddr_MEM), .regWriteData_MEM(regWriteData_MEM),
    .Tnew_MEM(Tnew_MEM), .regaddr_WB(regaddr_WB), .regdata_WB(regdata_WB),
    .regWriteData(regWriteData), .addrErr(addrErr), .instr_WB(instr_WB),
    .PC_WB(PC_WB), .regWriteAddr_WB(regWriteAddr_WB),
    .regWriteData_WB(regWriteData_WB), .Tnew_WB(Tnew_WB)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;
  logic [31:0] pc = 32'h0000_3000;

  // Reference model: flat byte memory plus the expected MEM/WB contents.
  logic [7:0]  bmem [16384];
  logic [5:0]  m_instr;
  logic [31:0] m_pc, m_wd;
  logic [4:0]  m_wa;
  logic [1:0]  m_tnew;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_ld(input logic [5:0] i);
    return i inside {ILW, ILH, ILHU, ILB, ILBU};
  endfunction

  function automatic bit is_st(input logic [5:0] i);
    return i inside {ISW, ISH, ISB};
  endfunction

  function automatic bit m_err(input logic [5:0] i, input logic [31:0] a);
    if (!is_ld(i) && !is_st(i)) return 1'b0;
    if (a > 32'h3FFF) return 1'b1;
    if ((i == ILW || i == ISW) && (a % 4 != 0)) return 1'b1;
    if ((i == ILH || i == ILHU || i == ISH) && (a % 2 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] i, input logic [31:0] a);
    int n;
    logic [15:0] h;
    logic [7:0]  b;
    n = int'(a[13:0]);
    h = (n + 1 < 16384) ? {bmem[n+1], bmem[n]} : 16'h0;
    b = bmem[n];
    case (i)
      ILW:     return {bmem[n+3], bmem[n+2], bmem[n+1], bmem[n]};
      ILH:     return {{16{h[15]}}, h};
      ILHU:    return {16'h0, h};
      ILB:     return {{24{b[7]}}, b};
      default: return {24'h0, b};
    endcase
  endfunction

  function automatic logic [31:0] m_result();
    if (!is_ld(instr_MEM)) return regWriteData_MEM;
    if (m_err(instr_MEM, aluOut_MEM)) return 32'h0;
    return m_load(instr_MEM, aluOut_MEM);
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] res, d;
    int n;
    res = m_result();
    if (reset) begin
      for (int i = 0; i < 16384; i++) bmem[i] = 8'h00;
      m_instr = 0; m_pc = 0; m_wa = 0; m_wd = 0; m_tnew = 0;
    end else begin
      if (is_st(instr_MEM) && !m_err(instr_MEM, aluOut_MEM) && !stall) begin
        d = (regaddr_WB != 0 && regaddr_WB == addrRt_MEM) ? regdata_WB : memWriteData_MEM;
        n = int'(aluOut_MEM[13:0]);
        bmem[n] = d[7:0];
        if (instr_MEM != ISB) bmem[n+1] = d[15:8];
        if (instr_MEM == ISW) begin bmem[n+2] = d[23:16]; bmem[n+3] = d[31:24]; end
      end
      if (clr) begin
        m_instr = 0; m_pc = 0; m_wa = 0; m_wd = 0; m_tnew = 0;
      end else if (!stall) begin
        m_instr = instr_MEM; m_pc = PC_MEM; m_wa = regWriteAddr_MEM; m_wd = res;
        m_tnew  = (Tnew_MEM == 0) ? 2'd0 : Tnew_MEM - 2'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("regWriteData", regWriteData, m_result());
      chk("addrErr", {31'b0, addrErr}, {31'b0, m_err(instr_MEM, aluOut_MEM)});
      chk("instr_WB", {26'b0, instr_WB}, {26'b0, m_instr});
      chk("PC_WB", PC_WB, m_pc);
      chk("regWriteAddr_WB", {27'b0, regWriteAddr_WB}, {27'b0, m_wa});
      chk("regWriteData_WB", regWriteData_WB, m_wd);
      chk("Tnew_WB", {30'b0, Tnew_WB}, {30'b0, m_tnew});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [5:0] ins, input logic [31:0] a, input logic [31:0] d);
    instr_MEM        = ins;
    aluOut_MEM       = a;
    memWriteData_MEM = d;
    PC_MEM           = pc;
    pc               = pc + 4;
    addrRt_MEM       = 5'd7;
    regaddr_WB       = 5'd0;
    regdata_WB       = 32'h0;
    regWriteAddr_MEM = is_ld(ins) ? 5'd2 : 5'd0;
    regWriteData_MEM = $urandom;
    Tnew_MEM         = 2'd0;
  endtask

  task automatic wb_zero(input string tag);
    chk({tag, ".instr_WB"}, {26'b0, instr_WB}, 32'h0);
    chk({tag, ".PC_WB"}, PC_WB, 32'h0);
    chk({tag, ".regWriteAddr_WB"}, {27'b0, regWriteAddr_WB}, 32'h0);
    chk({tag, ".regWriteData_WB"}, regWriteData_WB, 32'h0);
    chk({tag, ".Tnew_WB"}, {30'b0, Tnew_WB}, 32'h0);
  endtask

  task automatic ld_chk(input string name, input logic [5:0] ins, input logic [31:0] a,
                        input logic [31:0] exp);
    op(ins, a, 32'h0);
    #1 chk(name, regWriteData, exp);
    tick();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; clr = 1'b0;
    op(INOP, 32'h0, 32'h0);
    regWriteData_MEM = 32'h0;
    tick(); tick();
    reset = 1'b0;
    cmp_on = 1'b1;
    wb_zero("reset");

    // word write then read; WB value one edge later
    op(ISW, 32'h10, 32'hDEADBEEF); tick();
    op(ILW, 32'h10, 32'h0);
    #1 chk("lw_comb", regWriteData, 32'hDEADBEEF);
    tick();
    chk("lw_wb", regWriteData_WB, 32'hDEADBEEF);

    // sub-word
    op(ISW, 32'h20, 32'h11223344); tick();
    op(ISB, 32'h21, 32'h000000AA); tick();
    ld_chk("lw_20", ILW, 32'h20, 32'h1122AA44);
    ld_chk("lb_21", ILB, 32'h21, 32'hFFFFFFAA);
    ld_chk("lbu_21", ILBU, 32'h21, 32'h000000AA);
    op(ISH, 32'h22, 32'h00008001); tick();
    ld_chk("lh_22", ILH, 32'h22, 32'hFFFF8001);
    ld_chk("lhu_22", ILHU, 32'h22, 32'h00008001);

    // forwarding from WB into store data, then the $0 case
    op(ISW, 32'h30, 32'h0); addrRt_MEM = 5'd5; regaddr_WB = 5'd5; regdata_WB = 32'h0000CAFE;
    tick();
    ld_chk("fwd_on", ILW, 32'h30, 32'h0000CAFE);
    op(ISW, 32'h30, 32'h0); addrRt_MEM = 5'd0; regaddr_WB = 5'd0; regdata_WB = 32'h0000CAFE;
    tick();
    ld_chk("fwd_zero", ILW, 32'h30, 32'h0);

    // address errors
    op(ILW, 32'h02, 32'h0);
    #1 chk("lw02_err", {31'b0, addrErr}, 32'h1);
    chk("lw02_data", regWriteData, 32'h0);
    tick();
    op(ISW, 32'h40, 32'h55667788); tick();
    op(ISH, 32'h41, 32'hFFFFFFFF);
    #1 chk("sh41_err", {31'b0, addrErr}, 32'h1);
    tick();
    ld_chk("sh41_nowrite", ILW, 32'h40, 32'h55667788);
    op(ISW, 32'h4000, 32'h12345678);
    #1 chk("sw4000_err", {31'b0, addrErr}, 32'h1);
    tick();
    ld_chk("sw4000_nowrite", ILW, 32'h0, 32'h0);
    op(ISW, 32'h3FFC, 32'hA5A5_5A5A); tick();
    ld_chk("last_word", ILW, 32'h3FFC, 32'hA5A5_5A5A);

    // stall holds MEM/WB and blocks the store
    op(ILW, 32'h10, 32'h0); PC_MEM = 32'h400; regWriteAddr_MEM = 5'd3; Tnew_MEM = 2'd2;
    tick();
    stall = 1'b1;
    op(ISW, 32'h10, 32'h0BADF00D);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("stall_pc", PC_WB, 32'h400);
      chk("stall_data", regWriteData_WB, 32'hDEADBEEF);
      chk("stall_addr", {27'b0, regWriteAddr_WB}, 32'd3);
      chk("stall_tnew", {30'b0, Tnew_WB}, 32'd1);
    end
    stall = 1'b0;
    ld_chk("stall_nowrite", ILW, 32'h10, 32'hDEADBEEF);

    // clr bubbles MEM/WB; store alongside clr still commits unless stalled
    clr = 1'b1;
    op(ISW, 32'h50, 32'h13572468);
    tick();
    wb_zero("clr");
    stall = 1'b1;
    op(ISW, 32'h54, 32'h24681357);
    tick();
    wb_zero("clr_stall");
    clr = 1'b0; stall = 1'b0;
    ld_chk("clr_store", ILW, 32'h50, 32'h13572468);
    ld_chk("clr_stall_store", ILW, 32'h54, 32'h0);

    // Tnew decrement
    op(IALU, 32'h0, 32'h0); Tnew_MEM = 2'd2; tick();
    chk("tnew2", {30'b0, Tnew_WB}, 32'd1);
    op(IALU, 32'h0, 32'h0); Tnew_MEM = 2'd0; tick();
    chk("tnew0", {30'b0, Tnew_WB}, 32'd0);

    // reset during a store
    reset = 1'b1;
    op(ISW, 32'h10, 32'h99999999);
    tick();
    reset = 1'b0;
    wb_zero("rst_mid");
    ld_chk("rst_mem10", ILW, 32'h10, 32'h0);
    ld_chk("rst_mem20", ILW, 32'h20, 32'h0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int r, sel;
      logic [31:0] a;
      r     = $urandom_range(0, 199);
      reset = (r == 0);
      stall = (r >= 1 && r <= 14);
      clr   = (r >= 15 && r <= 22);
      sel   = $urandom_range(0, 9);
      if (sel < 6)       a = $urandom_range(0, 255);
      else if (sel < 8)  a = $urandom_range(0, 255) & 32'hFFFF_FFFC;
      else if (sel == 8) a = 32'h3FF8 + $urandom_range(0, 11);
      else               a = $urandom;
      op(6'($urandom_range(0, 10)), a, $urandom);
      addrRt_MEM = 5'($urandom_range(0, 7));
      regaddr_WB = 5'($urandom_range(0, 7));
      regdata_WB = $urandom;
      regWriteAddr_MEM = 5'($urandom_range(0, 31));
      Tnew_MEM = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 1'b0; stall = 1'b0; clr = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_level.md
# mem_level

Pipeline MEM stage sitting between the EX stage and write-back. It owns the data memory, performs word/halfword/byte loads and stores at the address computed in EX, forwards the WB result into store data, and registers the results into the MEM/WB pipeline register. The combinational `regWriteData` result also feeds the hazard/forward network as `regdata_MEM`.

## Interface
Parameters:
- `DM_WORDS`, 4096: data-memory depth in 32-bit words (16 KiB, byte addresses 0x0000_0000–0x0000_3FFF).
- `DM_AW`, 12: word-index width, log2(`DM_WORDS`).

Ports (reset is `reset`, synchronous, active-high; clock is `clk`):
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `stall` input 1: hold MEM/WB register; suppress store commit.
- `clr` input 1: load a bubble (all zeros) into MEM/WB.
- `instr_MEM` input `WIDTH_INSTR`: decoded instruction id.
- `PC_MEM` input 32: instruction PC.
- `aluOut_MEM` input 32: effective byte address, or EX result.
- `memWriteData_MEM` input 32: store data from EX.
- `addrRt_MEM` input 5: rt index, used for store-data forwarding.
- `regWriteAddr_MEM` input 5: destination register (0 = none).
- `regWriteData_MEM` input 32: result produced upstream.
- `Tnew_MEM` input `WIDTH_T`: cycles until result ready.
- `regaddr_WB` input 5: WB destination, for forwarding.
- `regdata_WB` input 32: WB data, for forwarding.
- `regWriteData` output 32: combinational stage result, also `regdata_MEM`.
- `addrErr` output 1: combinational; current load/store is misaligned or out of range.
- `instr_WB` output `WIDTH_INSTR`: registered.
- `PC_WB` output 32: registered.
- `regWriteAddr_WB` output 5: registered.
- `regWriteData_WB` output 32: registered.
- `Tnew_WB` output `WIDTH_T`: registered.

## Operation
- Address handling:
  - `idx = aluOut_MEM[DM_AW+1:2]`, `off = aluOut_MEM[1:0]`.
  - In range means `aluOut_MEM[31:DM_AW+2] == 0`.
- Store data: `wdata = (regaddr_WB == addrRt_MEM && regaddr_WB != 0) ? regdata_WB : memWriteData_MEM`.
- Alignment rules:
  - LW/SW require `off == 0`.
  - LH/LHU/SH require `off[0] == 0`.
  - LB/LBU/SB accept any `off`.
  - `addrErr = memop && (misaligned || !inRange)`, where `memop` is FUNC_MEM_READ or FUNC_MEM_WRITE.
- Store byte enables:
  - SW: 4'b1111.
  - SH: 4'b0011 << off.
  - SB: 4'b0001 << off.
  - Byte lane k takes `wdata[8k+7:8k]` for SW. SH places `wdata[15:0]` in the selected half. SB places `wdata[7:0]` in the selected byte.
- Store commit: the memory write happens at posedge only if the instruction is a store, `!addrErr`, `!reset` and `!stall`. Only enabled bytes change.
- Load: asynchronous read of `mem[idx]`.
  - LW: the whole word.
  - LH: sign-extended half `off[1]`.
  - LHU: zero-extended half `off[1]`.
  - LB: sign-extended byte `off`.
  - LBU: zero-extended byte `off`.
  - If `addrErr`, the load result is 0.
- `regWriteData` = load result for loads, otherwise `regWriteData_MEM`.
- `Tnew = (Tnew_MEM >= 1) ? Tnew_MEM - 1 : 0`.
- MEM/WB register, in priority order:
  - `reset | clr`: every registered output becomes 0.
  - `!stall`: outputs capture `instr_MEM`, `PC_MEM`, `regWriteAddr_MEM`, `regWriteData`, `Tnew`.
  - `stall`: outputs hold.
- On `reset` all memory words are cleared to 0.

## Timing
- Reset values: all registered outputs are 0 and memory is all-zero one cycle after `reset` is sampled.
- A reset asserted mid-sequence discards any pending store in that cycle.
- Load-use latency:
  - Data appears on `regWriteData` in the same cycle the load is in MEM.
  - It appears on `regWriteData_WB` after the next posedge.
- Store followed by a load to the same word in the next cycle: the load sees the new data, since the write commits at the edge between them.
- Simultaneous `clr` and a store: the store still commits unless `stall`, because `clr` only bubbles MEM/WB.
- Simultaneous `stall` and `clr`: `clr` wins for the register, and the store is suppressed.
- The address wrap boundary is 0x3FFC, the last valid word. 0x4000 and above give `addrErr = 1`, with no write and a load result of 0.

## Test plan
- Write then read a word: SW data 0xDEADBEEF to 0x10, then LW 0x10. Required: `regWriteData_WB` = 0xDEADBEEF one edge after the LW is in MEM.
- Sub-word stores and loads:
  - Setup: SW 0x11223344 to 0x20, then SB data 0xAA to 0x21.
  - LW 0x20 returns 0x1122AA44.
  - LB 0x21 returns 0xFFFFFFAA.
  - LBU 0x21 returns 0x000000AA.
  - SH 0x8001 to 0x22, then LH 0x22 returns 0xFFFF8001 and LHU 0x22 returns 0x00008001.
- Forwarding: WB writes $5 = 0x0000CAFE while SW with rt=$5 (stale `memWriteData_MEM` 0) targets 0x30. Required: memory[0x30] = 0x0000CAFE. Repeat with `regaddr_WB` = 0: the stale 0 is stored.
- Errors:
  - LW 0x02 gives `addrErr` = 1 and `regWriteData` = 0.
  - SH 0x41 leaves memory unchanged.
  - SW 0x4000 gives `addrErr` = 1 and no write.
- Pipeline control:
  - With `stall` held 2 cycles, outputs stay constant and a stalled SW does not commit.
  - `clr` gives all outputs 0.
  - `Tnew_MEM` = 2 gives `Tnew_WB` = 1; `Tnew_MEM` = 0 gives 0.
- Reset mid-operation: SW to 0x10 in the same cycle as `reset`. Required: memory[0x10] = 0 and all outputs 0 afterwards.
